tx_stream_cipher: RTL and testbench



---
 rtl/tx_cipher_pkg.sv | 32 +++
 rtl/tx_stream_cipher_lane.sv | 37 +++
 rtl/tx_stream_cipher.sv | 195 +++++++++++++++++++
 tb/tb_tx_stream_cipher.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_cipher_pkg.sv
// Shared constants, FSM encoding and keystream helpers for tx_stream_cipher.
package tx_cipher_pkg;

    localparam int          XS_SHL_A      = 13;
    localparam int          XS_SHR_B      = 17;
    localparam int          XS_SHL_C      = 5;
    localparam logic [31:0] LANE_INC      = 32'h9E3779B9;
    localparam logic [31:0] SEED_FALLBACK = 32'h00000001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    function automatic logic [31:0] xorshift32(input logic [31:0] s);
        logic [31:0] x;
        x = s;
        x = x ^ (x << XS_SHL_A);
        x = x ^ (x >> XS_SHR_B);
        x = x ^ (x << XS_SHL_C);
        return x;
    endfunction

    // xorshift never leaves the all-zero state, so a zero seed is replaced.
    function automatic logic [31:0] lane_seed(input logic [31:0] base, input int unsigned lane);
        logic [31:0] v;
        v = base ^ (lane * LANE_INC);
        return (v == 32'h0) ? SEED_FALLBACK : v;
    endfunction

endpackage

// File: rtl/tx_stream_cipher_lane.sv
// keystream_lane: one 32-bit xorshift32 lane; load takes priority over advance.
module keystream_lane
    import tx_cipher_pkg::*;
#(
    parameter logic [31:0] RESET_VALUE = 32'h00000001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] load_value,
    input  logic        advance,
    output logic [31:0] state
);

    logic [31:0] state_q;
    logic [31:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = load_value;
        end else if (advance) begin
            state_d = xorshift32(state_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RESET_VALUE;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/tx_stream_cipher.sv
// Multi-lane xorshift32 stream cipher with SOF/TLAST framing and a 2-entry skid.
// Optional statistics outputs are enabled by defining TX_CIPHER_STATS_EN.
module tx_stream_cipher
    import tx_cipher_pkg::*;
#(
    parameter int C_DATA_WIDTH      = 32,
    parameter int C_FRAME_LEN_WIDTH = 16
) (
    input  logic                         i_aclk,
    input  logic                         i_areset,
    input  logic                         i_enable,
    input  logic                         i_bypass,
    input  logic                         i_reload,
    input  logic [31:0]                  i_seed,
    input  logic [C_FRAME_LEN_WIDTH-1:0] i_frame_len,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    input  logic [C_DATA_WIDTH-1:0]      s_axis_tdata,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic [C_DATA_WIDTH-1:0]      m_axis_tdata,
    output logic                         m_axis_sof,
    output logic                         m_axis_tlast,
    output logic                         o_busy
`ifdef TX_CIPHER_STATS_EN
    ,
    output logic [31:0]                  o_beat_count,
    output logic [15:0]                  o_frame_count
`endif
);

    localparam int C_LANES = C_DATA_WIDTH / 32;
    localparam int EW      = C_DATA_WIDTH + 2;
    localparam logic [C_FRAME_LEN_WIDTH-1:0] LEN_ONE = 1;

    state_e                       state_q, state_d;
    logic [1:0]                   occ_q, occ_d;
    logic [EW-1:0]                e0_q, e0_d, e1_q, e1_d;
    logic [C_FRAME_LEN_WIDTH-1:0] beat_cnt_q, beat_cnt_d, len_q, len_d;
    logic                         reload_pending_q, reload_pending_d;
    logic                         seed_init_q;

    logic                         accept, pop, to_idle, lane_load;
    logic                         sof_now, tlast_now;
    logic [C_FRAME_LEN_WIDTH-1:0] len_eff;
    logic [C_DATA_WIDTH-1:0]      keystream, out_word;
    logic [EW-1:0]                in_entry;

    genvar k;
    generate
        for (k = 0; k < C_LANES; k++) begin : g_lane
            keystream_lane #(
                .RESET_VALUE (lane_seed(32'h0, k))
            ) u_lane (
                .clk        (i_aclk),
                .reset      (i_areset),
                .load       (lane_load),
                .load_value (lane_seed(i_seed, k)),
                .advance    (accept),
                .state      (keystream[k*32 +: 32])
            );
        end
    endgenerate

    // Accept stops in the same cycle enable falls, so i_enable gates ready directly.
    assign s_axis_tready = (state_q == RUN) && i_enable && (occ_q < 2'd2)
                         && !(occ_q == 2'd1 && !m_axis_tready);
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign pop           = (occ_q != 2'd0) && m_axis_tready;

    assign len_eff   = (beat_cnt_q != '0) ? len_q
                     : ((i_frame_len == '0) ? LEN_ONE : i_frame_len);
    assign sof_now   = (beat_cnt_q == '0);
    assign tlast_now = (beat_cnt_q == (len_eff - LEN_ONE));
    assign out_word  = i_bypass ? s_axis_tdata : (s_axis_tdata ^ keystream);
    assign in_entry  = {sof_now, tlast_now, out_word};

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_enable) state_d = RUN;
            RUN:     if (!i_enable) state_d = DRAIN;
            DRAIN: begin
                if (i_enable && occ_q != 2'd0) state_d = RUN;
                else if (occ_q == 2'd0)        state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign to_idle = (state_q == DRAIN) && (state_d == IDLE);

    // A pending reseed lands at a frame boundary so the next SOF beat sees the new seed.
    always_comb begin
        lane_load = seed_init_q
                 || (state_q == IDLE && i_reload)
                 || (accept && tlast_now && (reload_pending_q || i_reload))
                 || (to_idle && (reload_pending_q || i_reload));
        reload_pending_d = reload_pending_q;
        if (lane_load) begin
            reload_pending_d = 1'b0;
        end else if (i_reload && state_q != IDLE) begin
            reload_pending_d = 1'b1;
        end
    end

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        len_d      = len_q;
        if (state_q == IDLE || to_idle) begin
            beat_cnt_d = '0;
        end else if (accept) begin
            beat_cnt_d = tlast_now ? '0 : beat_cnt_q + LEN_ONE;
            if (sof_now) len_d = len_eff;
        end
    end

    always_comb begin
        occ_d = occ_q;
        e0_d  = e0_q;
        e1_d  = e1_q;
        case ({accept, pop})
            2'b01: begin
                e0_d  = e1_q;
                occ_d = occ_q - 2'd1;
            end
            2'b10: begin
                if (occ_q == 2'd0) e0_d = in_entry;
                else               e1_d = in_entry;
                occ_d = occ_q + 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    e0_d = in_entry;
                end else begin
                    e0_d = e1_q;
                    e1_d = in_entry;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            state_q          <= IDLE;
            occ_q            <= 2'd0;
            e0_q             <= '0;
            e1_q             <= '0;
            beat_cnt_q       <= '0;
            len_q            <= '0;
            reload_pending_q <= 1'b0;
            seed_init_q      <= 1'b1;
        end else begin
            state_q          <= state_d;
            occ_q            <= occ_d;
            e0_q             <= e0_d;
            e1_q             <= e1_d;
            beat_cnt_q       <= beat_cnt_d;
            len_q            <= len_d;
            reload_pending_q <= reload_pending_d;
            seed_init_q      <= 1'b0;
        end
    end

    assign m_axis_tvalid = (occ_q != 2'd0);
    assign m_axis_tdata  = e0_q[C_DATA_WIDTH-1:0];
    assign m_axis_tlast  = e0_q[C_DATA_WIDTH];
    assign m_axis_sof    = e0_q[C_DATA_WIDTH+1];
    assign o_busy        = (state_q != IDLE) || (occ_q != 2'd0);

`ifdef TX_CIPHER_STATS_EN
    logic [31:0] beat_count_q, beat_count_d;
    logic [15:0] frame_count_q, frame_count_d;

    always_comb begin
        beat_count_d  = accept ? beat_count_q + 32'd1 : beat_count_q;
        frame_count_d = (pop && e0_q[C_DATA_WIDTH]) ? frame_count_q + 16'd1 : frame_count_q;
    end

    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            beat_count_q  <= '0;
            frame_count_q <= '0;
        end else begin
            beat_count_q  <= beat_count_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign o_beat_count  = beat_count_q;
    assign o_frame_count = frame_count_q;
`endif

endmodule

// File: tb/tb_tx_stream_cipher.sv
// Directed bench for tx_stream_cipher: 32-bit instance for framing/flow tests, 64-bit for lane seeding.
module tb_tx_stream_cipher;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable, bypass, reload;
    logic [31:0] seed;
    logic [15:0] flen;
    logic        s_tvalid, s_tready, m_tvalid, m_tready, m_sof, m_tlast, busy;
    logic [31:0] s_tdata, m_tdata;

    logic        w_enable, w_s_tvalid, w_s_tready, w_m_tvalid, w_m_tready, w_sof, w_last, w_busy;
    logic [63:0] w_s_tdata, w_m_tdata;

    int checks = 0;
    int errors = 0;

    logic [33:0] out_q[$];
    logic [65:0] wout_q[$];

    always #5 clk = ~clk;

    tx_stream_cipher #(.C_DATA_WIDTH(32), .C_FRAME_LEN_WIDTH(16)) dut (
        .i_aclk(clk), .i_areset(rst), .i_enable(enable), .i_bypass(bypass),
        .i_reload(reload), .i_seed(seed), .i_frame_len(flen),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
        .m_axis_sof(m_sof), .m_axis_tlast(m_tlast), .o_busy(busy)
    );

    tx_stream_cipher #(.C_DATA_WIDTH(64), .C_FRAME_LEN_WIDTH(16)) dut64 (
        .i_aclk(clk), .i_areset(rst), .i_enable(w_enable), .i_bypass(1'b0),
        .i_reload(1'b0), .i_seed(32'h0), .i_frame_len(16'd4),
        .s_axis_tvalid(w_s_tvalid), .s_axis_tready(w_s_tready), .s_axis_tdata(w_s_tdata),
        .m_axis_tvalid(w_m_tvalid), .m_axis_tready(w_m_tready), .m_axis_tdata(w_m_tdata),
        .m_axis_sof(w_sof), .m_axis_tlast(w_last), .o_busy(w_busy)
    );

    // Output beats are recorded on the falling edge; the handshake completes on the next rising edge.
    always @(negedge clk) begin
        if (m_tvalid && m_tready)     out_q.push_back({m_sof, m_tlast, m_tdata});
        if (w_m_tvalid && w_m_tready) wout_q.push_back({w_sof, w_last, w_m_tdata});
    end

    function automatic logic [31:0] xs(input logic [31:0] s);
        logic [31:0] x;
        x = s;
        x = x ^ (x << 13);
        x = x ^ (x >> 17);
        x = x ^ (x << 5);
        return x;
    endfunction

    function automatic logic [31:0] ks_at(input logic [31:0] s0, input int n);
        logic [31:0] s;
        s = s0;
        for (int i = 0; i < n; i++) s = xs(s);
        return s;
    endfunction

    task automatic do_reset(input logic [31:0] sd, input logic [15:0] fl);
        enable = 0; bypass = 0; reload = 0; s_tvalid = 0; s_tdata = '0; m_tready = 1;
        w_enable = 0; w_s_tvalid = 0; w_s_tdata = '0; w_m_tready = 1;
        seed = sd; flen = fl;
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(posedge clk); #1;
        out_q.delete();
        wout_q.delete();
    endtask

    task automatic drive_beat(input logic [31:0] d);
        int n;
        n = 0;
        s_tdata = d;
        s_tvalid = 1;
        @(negedge clk);
        while (!s_tready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!s_tready) begin
            checks++; errors++;
            $display("FAIL drive_timeout: s_axis_tready=%0b required 1", s_tready);
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_out(input int n);
        int c;
        c = 0;
        while (out_q.size() < n && c < 200) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (out_q.size() != n) begin
            errors++;
            $display("FAIL out_count: got %0d beats required %0d", out_q.size(), n);
        end
    endtask

    task automatic test_reset();
        enable = 1; reload = 1; s_tvalid = 1; s_tdata = 32'hFFFFFFFF; m_tready = 1; seed = 32'h5; flen = 16'd4;
        w_enable = 1; w_s_tvalid = 1; w_s_tdata = '1; w_m_tready = 1; bypass = 0;
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %0b required 0", m_tvalid); end
        checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL reset_tready: got %0b required 0", s_tready); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %0b required 0", busy); end
        checks++; if (m_sof !== 1'b0)    begin errors++; $display("FAIL reset_sof: got %0b required 0", m_sof); end
        checks++; if (m_tlast !== 1'b0)  begin errors++; $display("FAIL reset_tlast: got %0b required 0", m_tlast); end
        checks++; if (m_tdata !== 32'h0) begin errors++; $display("FAIL reset_tdata: got %h required 0", m_tdata); end
        checks++; if (w_m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_w_tvalid: got %0b required 0", w_m_tvalid); end
    endtask

    task automatic test_basic();
        logic [33:0] e;
        do_reset(32'h1, 16'd4);
        enable = 1;
        for (int i = 0; i < 8; i++) drive_beat(32'h0);
        s_tvalid = 0;
        wait_out(8);
        e = out_q[0];
        checks++; if (e[31:0] !== 32'h00000001) begin errors++; $display("FAIL basic_word0: got %h required 00000001", e[31:0]); end
        e = out_q[1];
        checks++; if (e[31:0] !== 32'h00042021) begin errors++; $display("FAIL basic_word1: got %h required 00042021", e[31:0]); end
        for (int i = 0; i < 8; i++) begin
            e = out_q[i];
            checks++;
            if (e !== {(i % 4 == 0), (i % 4 == 3), ks_at(32'h1, i)}) begin
                errors++;
                $display("FAIL basic_beat%0d: got %h required %h", i, e, {(i % 4 == 0), (i % 4 == 3), ks_at(32'h1, i)});
            end
        end
    endtask

    task automatic test_wide();
        int c;
        logic [65:0] e;
        do_reset(32'h0, 16'd4);
        w_enable = 1;
        for (int b = 0; b < 2; b++) begin
            w_s_tdata = '0; w_s_tvalid = 1; c = 0;
            @(negedge clk);
            while (!w_s_tready && c < 200) begin @(negedge clk); c++; end
            @(posedge clk); #1;
        end
        w_s_tvalid = 0;
        c = 0;
        while (wout_q.size() < 2 && c < 200) begin @(negedge clk); c++; end
        checks++; if (wout_q.size() != 2) begin errors++; $display("FAIL wide_count: got %0d required 2", wout_q.size()); end
        e = wout_q[0];
        checks++; if (e !== {2'b10, 64'h9E3779B9_00000001}) begin errors++; $display("FAIL wide_beat0: got %h required %h", e, {2'b10, 64'h9E3779B9_00000001}); end
        e = wout_q[1];
        checks++; if (e !== {2'b00, xs(32'h9E3779B9), 32'h00042021}) begin errors++; $display("FAIL wide_beat1: got %h required %h", e, {2'b00, xs(32'h9E3779B9), 32'h00042021}); end
        w_enable = 0;
    endtask

    task automatic test_backpressure();
        logic [31:0] sent[8];
        logic        saw_block;
        logic [33:0] e;
        saw_block = 0;
        do_reset(32'h12345678, 16'd3);
        enable = 1;
        for (int i = 0; i < 8; i++) sent[i] = 32'h11111111 * (i + 1);
        fork
            begin
                for (int i = 0; i < 8; i++) drive_beat(sent[i]);
                s_tvalid = 0;
            end
            begin
                logic        prev_stall;
                logic [31:0] prev_d;
                prev_stall = 0; prev_d = '0;
                for (int c = 0; c < 48; c++) begin
                    m_tready = (c % 4 == 0) || (c % 4 == 3);
                    @(negedge clk);
                    if (prev_stall && m_tvalid) begin
                        checks++;
                        if (m_tdata !== prev_d) begin errors++; $display("FAIL stall_stable: got %h required %h", m_tdata, prev_d); end
                    end
                    if (s_tvalid && !s_tready && m_tvalid) saw_block = 1;
                    prev_stall = m_tvalid && !m_tready;
                    prev_d = m_tdata;
                    @(posedge clk); #1;
                end
            end
        join
        m_tready = 1;
        checks++; if (saw_block !== 1'b1) begin errors++; $display("FAIL bp_ready_drop: got %0b required 1", saw_block); end
        wait_out(8);
        for (int i = 0; i < 8; i++) begin
            e = out_q[i];
            checks++;
            if (e !== {(i % 3 == 0), (i % 3 == 2), sent[i] ^ ks_at(32'h12345678, i)}) begin
                errors++;
                $display("FAIL bp_beat%0d: got %h required %h", i, e, {(i % 3 == 0), (i % 3 == 2), sent[i] ^ ks_at(32'h12345678, i)});
            end
        end
    endtask

    task automatic test_reload();
        logic [33:0] e;
        logic [31:0] exp_ks;
        do_reset(32'hCAFEBABE, 16'd4);
        enable = 1;
        drive_beat(32'h100);
        drive_beat(32'h101);
        s_tvalid = 0;
        seed = 32'h0BADF00D;
        reload = 1;
        @(posedge clk); #1;
        reload = 0;
        for (int i = 2; i < 8; i++) drive_beat(32'h100 + i);
        s_tvalid = 0;
        wait_out(8);
        for (int i = 0; i < 8; i++) begin
            e = out_q[i];
            exp_ks = (i < 4) ? ks_at(32'hCAFEBABE, i) : ks_at(32'h0BADF00D, i - 4);
            checks++;
            if (e !== {(i % 4 == 0), (i % 4 == 3), (32'h100 + i) ^ exp_ks}) begin
                errors++;
                $display("FAIL reload_beat%0d: got %h required %h", i, e, {(i % 4 == 0), (i % 4 == 3), (32'h100 + i) ^ exp_ks});
            end
        end
    endtask

    task automatic test_drain();
        int c;
        logic [33:0] e;
        do_reset(32'h2468ACE1, 16'd4);
        enable = 1;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drain_busy_run: got %0b required 1", busy); end
        drive_beat(32'h0);
        drive_beat(32'h0);
        s_tvalid = 0;
        enable = 0;
        c = 0;
        while (busy && c < 50) begin @(negedge clk); c++; end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drain_busy_idle: got %0b required 0", busy); end
        checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL drain_ready_idle: got %0b required 0", s_tready); end
        wait_out(2);
        e = out_q[0];
        checks++; if (e !== {2'b10, ks_at(32'h2468ACE1, 0)}) begin errors++; $display("FAIL drain_beat0: got %h required %h", e, {2'b10, ks_at(32'h2468ACE1, 0)}); end
        e = out_q[1];
        checks++; if (e !== {2'b00, ks_at(32'h2468ACE1, 1)}) begin errors++; $display("FAIL drain_beat1: got %h required %h", e, {2'b00, ks_at(32'h2468ACE1, 1)}); end
        out_q.delete();
        @(posedge clk); #1;
        enable = 1;
        drive_beat(32'h0);
        s_tvalid = 0;
        wait_out(1);
        e = out_q[0];
        checks++; if (e !== {2'b10, ks_at(32'h2468ACE1, 2)}) begin errors++; $display("FAIL drain_reenable: got %h required %h", e, {2'b10, ks_at(32'h2468ACE1, 2)}); end
    endtask

    task automatic test_bypass();
        logic [33:0] e;
        do_reset(32'h13579BDF, 16'd0);
        bypass = 1;
        enable = 1;
        drive_beat(32'hDEADBEEF);
        bypass = 0;
        drive_beat(32'h0);
        drive_beat(32'h0);
        s_tvalid = 0;
        wait_out(3);
        e = out_q[0];
        checks++; if (e !== {2'b11, 32'hDEADBEEF}) begin errors++; $display("FAIL bypass_word: got %h required %h", e, {2'b11, 32'hDEADBEEF}); end
        e = out_q[1];
        checks++; if (e !== {2'b11, ks_at(32'h13579BDF, 1)}) begin errors++; $display("FAIL bypass_after1: got %h required %h", e, {2'b11, ks_at(32'h13579BDF, 1)}); end
        e = out_q[2];
        checks++; if (e !== {2'b11, ks_at(32'h13579BDF, 2)}) begin errors++; $display("FAIL bypass_after2: got %h required %h", e, {2'b11, ks_at(32'h13579BDF, 2)}); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wide();
        test_backpressure();
        test_reload();
        test_drain();
        test_bypass();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
